// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the write-back stage record for the
// integer-pipeline back end (EX/MEM, MEM/WB, register file).
package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  ReadEnable   = 1'b1;
    localparam logic                  ReadDisable  = 1'b0;
    localparam logic                  RstEnable    = 1'b0;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     data;
    } wb_stage_t;

    localparam wb_stage_t StageBubble = '{wd: NOPRegAddr, wreg: WriteDisable, data: ZeroWord};

    // True when a stage carries a live result for the given register.
    function automatic logic stage_hit(input wb_stage_t s, input logic [RegAddrBus-1:0] addr);
        return (s.wreg == WriteEnable) && (s.wd == addr);
    endfunction

endpackage

// File: rtl/wb_regfile_regfile.sv
// 32x32 register array with one commit port and two read ports that
// bypass the result being committed in the same cycle.
module wb_regfile_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  wb_stage_t             commit_i,
    input  logic                  re1_i,
    input  logic [RegAddrBus-1:0] raddr1_i,
    input  logic                  re2_i,
    input  logic [RegAddrBus-1:0] raddr2_i,
    output logic [RegBus-1:0]     rdata1_o,
    output logic [RegBus-1:0]     rdata2_o
);

    logic [RegNum-1:0][RegBus-1:0] regs_d;
    logic [RegNum-1:0][RegBus-1:0] regs_q;

    function automatic logic [RegBus-1:0] read_port(
        input logic                          rst_n,
        input logic                          re,
        input logic [RegAddrBus-1:0]         addr,
        input wb_stage_t                     wb,
        input logic [RegNum-1:0][RegBus-1:0] regs
    );
        if (rst_n == RstEnable || re != ReadEnable || addr == NOPRegAddr) begin
            return ZeroWord;
        end
        if (stage_hit(wb, addr)) begin
            return wb.data;
        end
        return regs[addr];
    endfunction

    // r0 is hardwired: commits addressed to it are dropped.
    always_comb begin
        regs_d = regs_q;
        if (commit_i.wreg == WriteEnable && commit_i.wd != NOPRegAddr) begin
            regs_d[commit_i.wd] = commit_i.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1_o = read_port(rst, re1_i, raddr1_i, commit_i, regs_q);
        rdata2_o = read_port(rst, re2_i, raddr2_i, commit_i, regs_q);
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back back end: EX/MEM and MEM/WB pipeline registers feeding the
// register file, with full forwarding on both decode read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [RegAddrBus-1:0] ex_wd_i,
    input  logic                  ex_wreg_i,
    input  logic [RegBus-1:0]     ex_wdata_i,
    input  logic                  re1_i,
    input  logic                  re2_i,
    input  logic [RegAddrBus-1:0] raddr1_i,
    input  logic [RegAddrBus-1:0] raddr2_i,
    output logic [RegBus-1:0]     rdata1_o,
    output logic [RegBus-1:0]     rdata2_o,
    output logic [RegAddrBus-1:0] wb_wd_o,
    output logic                  wb_wreg_o,
    output logic [RegBus-1:0]     wb_wdata_o
);

    wb_stage_t         ex_s;
    wb_stage_t         exmem_d;
    wb_stage_t         exmem_q;
    wb_stage_t         memwb_d;
    wb_stage_t         memwb_q;
    logic [RegBus-1:0] rf_rdata1;
    logic [RegBus-1:0] rf_rdata2;

    // Newer stages take priority; the register file already covers MEM/WB.
    function automatic logic [RegBus-1:0] resolve(
        input logic                  rst_n,
        input logic                  re,
        input logic [RegAddrBus-1:0] addr,
        input wb_stage_t             ex,
        input wb_stage_t             exmem,
        input logic [RegBus-1:0]     rf_data
    );
        if (rst_n == RstEnable || re != ReadEnable || addr == NOPRegAddr) begin
            return ZeroWord;
        end
        if (stage_hit(ex, addr)) begin
            return ex.data;
        end
        if (stage_hit(exmem, addr)) begin
            return exmem.data;
        end
        return rf_data;
    endfunction

    always_comb begin
        ex_s = '{wd: ex_wd_i, wreg: ex_wreg_i, data: ex_wdata_i};
    end

    // A stall holds EX/MEM and feeds a bubble forward so its result
    // reaches MEM/WB exactly once.
    always_comb begin
        exmem_d = ex_s;
        memwb_d = exmem_q;
        if (flush_i) begin
            exmem_d = StageBubble;
            memwb_d = StageBubble;
        end else if (stall_i) begin
            exmem_d = exmem_q;
            memwb_d = StageBubble;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            exmem_q <= StageBubble;
            memwb_q <= StageBubble;
        end else begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    wb_regfile_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .commit_i (memwb_q),
        .re1_i    (re1_i),
        .raddr1_i (raddr1_i),
        .re2_i    (re2_i),
        .raddr2_i (raddr2_i),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    always_comb begin
        rdata1_o = resolve(rst, re1_i, raddr1_i, ex_s, exmem_q, rf_rdata1);
        rdata2_o = resolve(rst, re2_i, raddr2_i, ex_s, exmem_q, rf_rdata2);
    end

    assign wb_wd_o    = memwb_q.wd;
    assign wb_wreg_o  = memwb_q.wreg;
    assign wb_wdata_o = memwb_q.data;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all checked against an in-flight-queue reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic        re1_i;
    logic        re2_i;
    logic [4:0]  raddr1_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ex_wd_i    (ex_wd_i),
        .ex_wreg_i  (ex_wreg_i),
        .ex_wdata_i (ex_wdata_i),
        .re1_i      (re1_i),
        .re2_i      (re2_i),
        .raddr1_i   (raddr1_i),
        .raddr2_i   (raddr2_i),
        .rdata1_o   (rdata1_o),
        .rdata2_o   (rdata2_o),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o)
    );

    // Reference model: committed array plus the list of accepted results
    // still in flight, each tagged with the cycle it shows on wb_*.
    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
        int          wb_cyc;
    } pend_t;

    pend_t       q[$];
    logic [31:0] m_arr[32];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          wb_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'd0;
        if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wd == a) return q[i].data;
        end
        return m_arr[a];
    endfunction

    task automatic settle();
        int k;
        @(negedge clk);
        chk("rdata1", rdata1_o, m_read(re1_i, raddr1_i));
        chk("rdata2", rdata2_o, m_read(re2_i, raddr2_i));
        if (wb_known) begin
            k = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].wb_cyc == cyc) k = i;
            end
            chk("wb_wreg", 32'(wb_wreg_o), 32'(k >= 0));
            if (k >= 0) begin
                chk("wb_wd", 32'(wb_wd_o), 32'(q[k].wd));
                chk("wb_wdata", wb_wdata_o, q[k].data);
            end
        end
    endtask

    task automatic clk_edge();
        pend_t p;
        if (!rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
            wb_known = 1'b1;
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].wb_cyc == cyc) begin
                    if (q[i].wd != 5'd0) m_arr[q[i].wd] = q[i].data;
                    q.delete(i);
                end
            end
            if (flush_i) begin
                q.delete();
            end else if (stall_i) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].wb_cyc == cyc + 1) q[i].wb_cyc = cyc + 2;
                end
            end else if (ex_wreg_i) begin
                p.wd     = ex_wd_i;
                p.data   = ex_wdata_i;
                p.wb_cyc = cyc + 2;
                q.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ex_idle();
        ex_wreg_i  = 1'b0;
        ex_wd_i    = 5'd0;
        ex_wdata_i = 32'd0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic ex_write(input logic [4:0] wd, input logic [31:0] data);
        ex_wreg_i  = 1'b1;
        ex_wd_i    = wd;
        ex_wdata_i = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
        rst = 1'b0;
        ex_idle();
        re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd1; raddr2_i = 5'd2;

        // Reset clear
        settle(); chk("rst_rdata1", rdata1_o, 32'd0); clk_edge();
        settle(); chk("rst_wbwreg", 32'(wb_wreg_o), 32'd0); clk_edge();
        rst = 1'b1;
        for (int a = 1; a < 32; a++) begin
            raddr1_i = 5'(a); raddr2_i = 5'(32 - a);
            settle();
            chk("reset_clear", rdata1_o, 32'd0);
            chk("reset_wbwreg", 32'(wb_wreg_o), 32'd0);
            clk_edge();
        end

        // Back-to-back dependency: one write seen through every source
        raddr1_i = 5'd3; raddr2_i = 5'd3;
        ex_write(5'd3, 32'h0000_00FF);
        for (int c = 0; c < 4; c++) begin
            settle(); chk("b2b_ff", rdata1_o, 32'h0000_00FF); clk_edge();
            ex_idle();
        end
        ex_write(5'd3, 32'h0000_0AAA);
        settle(); clk_edge();
        ex_write(5'd3, 32'h0000_0F00);
        for (int c = 0; c < 4; c++) begin
            settle(); chk("b2b_waw", rdata1_o, 32'h0000_0F00); clk_edge();
            ex_idle();
        end

        // r0 protection
        raddr1_i = 5'd0;
        ex_write(5'd0, 32'hDEAD_BEEF);
        settle(); chk("r0_read", rdata1_o, 32'd0); clk_edge();
        ex_idle();
        settle(); chk("r0_read", rdata1_o, 32'd0); clk_edge();
        settle();
        chk("r0_wbwreg", 32'(wb_wreg_o), 32'd1);
        chk("r0_wbwd", 32'(wb_wd_o), 32'd0);
        clk_edge();
        settle(); chk("r0_read", rdata1_o, 32'd0); clk_edge();

        // Stall: commit happens once, after release
        raddr1_i = 5'd5;
        ex_write(5'd5, 32'h0000_1234);
        settle(); chk("stall_rd", rdata1_o, 32'h1234); clk_edge();
        ex_idle(); stall_i = 1'b1;
        settle(); chk("stall_rd", rdata1_o, 32'h1234); clk_edge();
        settle(); chk("stall_wb_n2", 32'(wb_wreg_o), 32'd0); chk("stall_rd", rdata1_o, 32'h1234); clk_edge();
        stall_i = 1'b0;
        settle(); chk("stall_wb_n3", 32'(wb_wreg_o), 32'd0); chk("stall_rd", rdata1_o, 32'h1234); clk_edge();
        settle();
        chk("stall_wb_n4", 32'(wb_wreg_o), 32'd1);
        chk("stall_wbdata", wb_wdata_o, 32'h1234);
        clk_edge();
        settle(); chk("stall_once", 32'(wb_wreg_o), 32'd0); chk("stall_rd", rdata1_o, 32'h1234); clk_edge();

        // Flush: preload r7, then kill an in-flight overwrite
        raddr1_i = 5'd7;
        ex_write(5'd7, 32'h11);
        settle(); clk_edge();
        ex_idle();
        repeat (3) begin settle(); clk_edge(); end
        ex_write(5'd7, 32'h22);
        settle(); clk_edge();
        ex_idle(); flush_i = 1'b1;
        settle(); chk("flush_rd_n1", rdata1_o, 32'h22); clk_edge();
        flush_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("flush_rd", rdata1_o, 32'h11);
            chk("flush_nocommit", 32'(wb_wreg_o), 32'd0);
            clk_edge();
        end

        // Read enables
        ex_write(5'd9, 32'hAA);
        settle(); clk_edge();
        ex_idle();
        repeat (3) begin settle(); clk_edge(); end
        re1_i = 1'b0; re2_i = 1'b1; raddr1_i = 5'd9; raddr2_i = 5'd9;
        settle();
        chk("re1_off", rdata1_o, 32'd0);
        chk("re2_on", rdata2_o, 32'hAA);
        clk_edge();

        // Random traffic, including stalls, flushes and mid-run resets
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(63) != 0);
            stall_i    = ($urandom_range(7) == 0);
            flush_i    = ($urandom_range(15) == 0);
            ex_wreg_i  = ($urandom_range(1) == 0);
            ex_wd_i    = 5'($urandom_range(7));
            ex_wdata_i = $urandom;
            re1_i      = ($urandom_range(3) != 0);
            re2_i      = ($urandom_range(3) != 0);
            raddr1_i   = 5'($urandom_range(7));
            raddr2_i   = ($urandom_range(3) == 0) ? raddr1_i : 5'($urandom_range(7));
            settle();
            if (re1_i && re2_i && raddr1_i == raddr2_i) chk("same_addr", rdata1_o, rdata2_o);
            clk_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
